// File: rtl/mandelbrot_iter_budget_pkg.sv
// Shared types and constants for the Mandelbrot iteration-budget block.
// Optional stats output is controlled by MANDELBROT_ITER_STATS_EN (see top).
package mandelbrot_pkg;

    localparam int DEFAULT_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chan_state_t;

endpackage

// File: rtl/mandelbrot_iter_budget_if.sv
// Result handshake bundle: the block drives results as master, the consumer returns ready.
interface mandelbrot_iter_budget_if
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = 4
);
    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic              res_valid;
    logic              res_ready;
    logic [CHAN_W-1:0] res_chan;
    logic [WIDTH-1:0]  res_count;
    logic              res_escaped;

    modport master (
        output res_valid, res_chan, res_count, res_escaped,
        input  res_ready
    );

    modport slave (
        input  res_valid, res_chan, res_count, res_escaped,
        output res_ready
    );

endinterface

// File: rtl/mandelbrot_iter_budget_chan.sv
// One iteration-budget channel: counts remaining iterations and latches its result until taken.
// The o_accept port exists only when MANDELBROT_ITER_STATS_EN is defined.
module mandelbrot_iter_chan
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_loadValue,
    input  logic             i_step,
    input  logic             i_escaped,
    input  logic             i_take,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_remaining,
    output logic [WIDTH-1:0] o_count,
    output logic             o_escaped
`ifdef MANDELBROT_ITER_STATS_EN
    ,
    output logic             o_accept
`endif
);

    chan_state_t      r_state;
    logic [WIDTH-1:0] r_origin;
    logic [WIDTH-1:0] r_remaining;
    logic [WIDTH-1:0] r_count;
    logic             r_escaped;

    // RUN is only entered with a non-zero budget and left at 1 -> 0, so remaining never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_origin    <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_escaped   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_origin    <= i_loadValue;
                        r_remaining <= i_loadValue;
                        if (i_loadValue == '0) begin
                            r_state   <= DONE;
                            r_count   <= '0;
                            r_escaped <= 1'b0;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (i_escaped) begin
                        r_state   <= DONE;
                        r_escaped <= 1'b1;
                        r_count   <= r_origin - r_remaining;
                    end else if (i_step) begin
                        r_remaining <= r_remaining - WIDTH'(1);
                        if (r_remaining == WIDTH'(1)) begin
                            r_state   <= DONE;
                            r_escaped <= 1'b0;
                            r_count   <= r_origin;
                        end
                    end
                end
                DONE: begin
                    if (i_take) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_remaining = r_remaining;
    assign o_count     = r_count;
    assign o_escaped   = r_escaped;
`ifdef MANDELBROT_ITER_STATS_EN
    assign o_accept    = (r_state == RUN) && i_step && !i_escaped;
`endif

endmodule

// File: rtl/mandelbrot_iter_budget.sv
// Multi-channel Mandelbrot iteration budget with a single arbitrated result slot.
// Define MANDELBROT_ITER_STATS_EN to add the saturating total_iter step counter.
module mandelbrot_iter_budget
    import mandelbrot_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    input  logic [CHANNELS-1:0]       step,
    input  logic [CHANNELS-1:0]       escaped,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*WIDTH-1:0] remaining,
    mandelbrot_iter_budget_if.master  res
`ifdef MANDELBROT_ITER_STATS_EN
    ,
    output logic [31:0]               total_iter
`endif
);

    localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic [CHANNELS-1:0] w_done;
    logic [CHANNELS-1:0] w_take;
    logic [CHANNELS-1:0] w_escFlag;
    logic [WIDTH-1:0]    w_count [CHANNELS];
    logic                w_found;
    logic [CHAN_W-1:0]   w_sel;
    logic                w_slotFree;
`ifdef MANDELBROT_ITER_STATS_EN
    logic [CHANNELS-1:0] w_accept;
`endif

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        mandelbrot_iter_chan #(.WIDTH(WIDTH)) u_chan (
            .clk         (clk),
            .reset       (reset),
            .i_load      (load[g]),
            .i_loadValue (load_value[g*WIDTH +: WIDTH]),
            .i_step      (step[g]),
            .i_escaped   (escaped[g]),
            .i_take      (w_take[g]),
            .o_busy      (busy[g]),
            .o_done      (w_done[g]),
            .o_remaining (remaining[g*WIDTH +: WIDTH]),
            .o_count     (w_count[g]),
            .o_escaped   (w_escFlag[g])
`ifdef MANDELBROT_ITER_STATS_EN
            ,
            .o_accept    (w_accept[g])
`endif
        );
        assign w_take[g] = w_slotFree && w_found && (w_sel == CHAN_W'(g));
    end

    // Lowest-index DONE channel wins; scanning downward leaves the lowest match last.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_done[i]) begin
                w_found = 1'b1;
                w_sel   = CHAN_W'(i);
            end
        end
    end

    assign w_slotFree = !res.res_valid || res.res_ready;

    // The slot refills on the same edge it is consumed, giving one result per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            res.res_valid   <= 1'b0;
            res.res_chan    <= '0;
            res.res_count   <= '0;
            res.res_escaped <= 1'b0;
        end else if (w_slotFree) begin
            res.res_valid <= w_found;
            if (w_found) begin
                res.res_chan    <= w_sel;
                res.res_count   <= w_count[w_sel];
                res.res_escaped <= w_escFlag[w_sel];
            end
        end
    end

`ifdef MANDELBROT_ITER_STATS_EN
    logic [4:0]  w_acceptCount;
    logic [32:0] w_sum;
    logic [31:0] r_total;

    always_comb begin
        w_acceptCount = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            w_acceptCount = w_acceptCount + 5'(w_accept[i]);
        end
    end

    assign w_sum = {1'b0, r_total} + 33'(w_acceptCount);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_total <= '0;
        end else begin
            r_total <= w_sum[32] ? '1 : w_sum[31:0];
        end
    end

    assign total_iter = r_total;
`endif

endmodule

// File: tb/tb_mandelbrot_iter_budget.sv
// Directed scoreboard bench for mandelbrot_iter_budget (also covers MANDELBROT_ITER_STATS_EN builds).
module tb_mandelbrot_iter_budget;
    import mandelbrot_pkg::*;

    localparam int W = 11;
    localparam int C = 4;

    typedef struct packed {
        logic [1:0]   chan;
        logic [W-1:0] count;
        logic         esc;
    } result_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [C-1:0]     load;
    logic [C*W-1:0]   load_value;
    logic [C-1:0]     step;
    logic [C-1:0]     escaped;
    logic [C-1:0]     busy;
    logic [C*W-1:0]   remaining;
`ifdef MANDELBROT_ITER_STATS_EN
    logic [31:0]      total_iter;
`endif

    result_t sbQueue[$];
    int      tests = 0;
    int      fails = 0;

    always #5 clk = ~clk;

    mandelbrot_iter_budget_if #(.WIDTH(W), .CHANNELS(C)) res ();

    mandelbrot_iter_budget #(.WIDTH(W), .CHANNELS(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .step       (step),
        .escaped    (escaped),
        .busy       (busy),
        .remaining  (remaining),
        .res        (res)
`ifdef MANDELBROT_ITER_STATS_EN
        ,
        .total_iter (total_iter)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [C-1:0] ldIn, input logic [C*W-1:0] lvIn,
                                 input logic [C-1:0] stIn, input logic [C-1:0] esIn);
        load       = ldIn;
        load_value = lvIn;
        step       = stIn;
        escaped    = esIn;
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input int ch, input int cnt, input logic esc);
        result_t r;
        r.chan  = 2'(ch);
        r.count = W'(cnt);
        r.esc   = esc;
        sbQueue.push_back(r);
    endtask

    function automatic logic [C*W-1:0] lvOne(input int ch, input int v);
        logic [C*W-1:0] x;
        x = '0;
        x[ch*W +: W] = W'(v);
        return x;
    endfunction

    function automatic logic [C*W-1:0] lvAll(input int v);
        logic [C*W-1:0] x;
        for (int i = 0; i < C; i++) x[i*W +: W] = W'(v);
        return x;
    endfunction

    function automatic logic [31:0] remOf(input int ch);
        return 32'(remaining[ch*W +: W]);
    endfunction

    // Every accepted handshake is checked against the oldest expected result.
    always @(negedge clk) begin
        if (!reset && res.res_valid && res.res_ready) begin
            checkOutput("sb_nonempty", 32'(sbQueue.size() != 0), 32'd1);
            if (sbQueue.size() != 0) begin
                result_t e;
                e = sbQueue.pop_front();
                checkOutput("sb_chan",    32'(res.res_chan),    32'(e.chan));
                checkOutput("sb_count",   32'(res.res_count),   32'(e.count));
                checkOutput("sb_escaped", 32'(res.res_escaped), 32'(e.esc));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset         = 1'b1;
        res.res_ready = 1'b1;
        applyStimulus('0, '0, '0, '0);
        applyStimulus('0, '0, '0, '0);
        checkOutput("rst_busy",    32'(busy),            32'd0);
        checkOutput("rst_valid",   32'(res.res_valid),   32'd0);
        checkOutput("rst_rem",     32'(remaining != '0), 32'd0);
        checkOutput("rst_chan",    32'(res.res_chan),    32'd0);
        checkOutput("rst_count",   32'(res.res_count),   32'd0);
        checkOutput("rst_escaped", 32'(res.res_escaped), 32'd0);
        reset = 1'b0;

        // Budget exhaustion on ch0: result two cycles after the final step
        applyStimulus(4'b0001, lvOne(0, 5), '0, '0);
        checkOutput("t1_busy", 32'(busy), 32'b0001);
        checkOutput("t1_rem",  remOf(0),  32'd5);
        repeat (5) applyStimulus('0, '0, 4'b0001, '0);
        pushExpected(0, 5, 1'b0);
        checkOutput("t1_valid_early", 32'(res.res_valid), 32'd0);
        checkOutput("t1_done_busy",   32'(busy),          32'b0001);
        checkOutput("t1_rem_zero",    remOf(0),           32'd0);
        applyStimulus('0, '0, '0, '0);
        checkOutput("t1_valid", 32'(res.res_valid), 32'd1);
        checkOutput("t1_idle",  32'(busy),          32'd0);
        applyStimulus('0, '0, '0, '0);
        checkOutput("t1_valid_drop", 32'(res.res_valid), 32'd0);

        // Step and escape on an idle channel must do nothing
        applyStimulus('0, '0, 4'b1000, 4'b1000);
        checkOutput("idle_ignore_busy", 32'(busy), 32'd0);
        checkOutput("idle_ignore_rem",  remOf(3),  32'd0);

        // Escape on ch1 wins over a simultaneous step
        applyStimulus(4'b0010, lvOne(1, 100), '0, '0);
        repeat (7) applyStimulus('0, '0, 4'b0010, '0);
        checkOutput("t2_rem_run", remOf(1), 32'd93);
        applyStimulus('0, '0, 4'b0010, 4'b0010);
        pushExpected(1, 7, 1'b1);
        checkOutput("t2_rem_done", remOf(1),     32'd93);
        checkOutput("t2_busy",     32'(busy[1]), 32'd1);
        applyStimulus('0, '0, '0, '0);
        checkOutput("t2_valid", 32'(res.res_valid), 32'd1);
        checkOutput("t2_chan",  32'(res.res_chan),  32'd1);
        applyStimulus('0, '0, '0, '0);

        // Zero budget goes straight to DONE
        applyStimulus(4'b0100, lvOne(2, 0), '0, '0);
        pushExpected(2, 0, 1'b0);
        checkOutput("t3_busy", 32'(busy), 32'b0100);
        applyStimulus('0, '0, '0, '0);
        checkOutput("t3_valid", 32'(res.res_valid), 32'd1);
        checkOutput("t3_chan",  32'(res.res_chan),  32'd2);
        applyStimulus('0, '0, '0, '0);

        // ch0 and ch3 finish together under backpressure; load during RUN is ignored
        res.res_ready = 1'b0;
        applyStimulus(4'b1001, lvOne(0, 3) | lvOne(3, 3), '0, '0);
        applyStimulus(4'b0001, lvOne(0, 9), '0, '0);
        checkOutput("t4_load_in_run", remOf(0), 32'd3);
        repeat (3) applyStimulus('0, '0, 4'b1001, '0);
        pushExpected(0, 3, 1'b0);
        pushExpected(3, 3, 1'b0);
        applyStimulus('0, '0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            checkOutput("t4_hold_valid", 32'(res.res_valid), 32'd1);
            checkOutput("t4_hold_chan",  32'(res.res_chan),  32'd0);
            checkOutput("t4_hold_count", 32'(res.res_count), 32'd3);
            checkOutput("t4_ch3_waits",  32'(busy[3]),       32'd1);
            applyStimulus('0, '0, '0, '0);
        end
        res.res_ready = 1'b1;
        applyStimulus('0, '0, '0, '0);
        checkOutput("t4_next_valid", 32'(res.res_valid), 32'd1);
        checkOutput("t4_next_chan",  32'(res.res_chan),  32'd3);
        checkOutput("t4_ch3_idle",   32'(busy[3]),       32'd0);
        applyStimulus('0, '0, '0, '0);
        checkOutput("t4_drained", 32'(res.res_valid), 32'd0);

        // Reset wins over load and step with every channel running
        applyStimulus(4'b1111, lvAll(10), '0, '0);
        repeat (2) applyStimulus('0, '0, 4'b1111, '0);
        reset = 1'b1;
        applyStimulus(4'b1111, lvAll(10), 4'b1111, '0);
        checkOutput("t5_busy",  32'(busy),            32'd0);
        checkOutput("t5_valid", 32'(res.res_valid),   32'd0);
        checkOutput("t5_rem",   32'(remaining != '0), 32'd0);
`ifdef MANDELBROT_ITER_STATS_EN
        checkOutput("t5_total", total_iter, 32'd0);
`endif
        reset = 1'b0;

        // Parallel steps on all channels, then a load attempt mid-run and escape
        applyStimulus(4'b1111, lvAll(5), '0, '0);
        repeat (3) applyStimulus('0, '0, 4'b1111, '0);
        applyStimulus(4'b1111, lvAll(9), '0, '0);
        for (int i = 0; i < C; i++) checkOutput("t6_rem", remOf(i), 32'd2);
`ifdef MANDELBROT_ITER_STATS_EN
        checkOutput("t6_total", total_iter, 32'd12);
`endif
        applyStimulus('0, '0, 4'b1111, 4'b1111);
        for (int i = 0; i < C; i++) pushExpected(i, 3, 1'b1);
`ifdef MANDELBROT_ITER_STATS_EN
        checkOutput("t6_total_esc", total_iter, 32'd12);
`endif
        applyStimulus('0, '0, '0, '0);
        for (int k = 0; k < 20 && sbQueue.size() != 0; k++) applyStimulus('0, '0, '0, '0);
        checkOutput("sb_drained", 32'(sbQueue.size()), 32'd0);
        applyStimulus('0, '0, '0, '0);
        checkOutput("final_valid", 32'(res.res_valid), 32'd0);
        checkOutput("final_busy",  32'(busy),          32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mandelbrot_iter_budget.md
MANDELBROT_ITER_BUDGET -- requirements
Module: mandelbrot_iter_budget

Interface
REQ-001 Parameter WIDTH, default 11: iteration-count width in bits.
REQ-002 Parameter CHANNELS, default 4: number of independent iteration counters; legal range 1..16.
REQ-003 Port clk, input, 1: clock; all logic on its rising edge.
REQ-004 Port reset, input, 1: reset; synchronous, active-high.
REQ-005 Port load, input, CHANNELS: per-channel start strobe.
REQ-006 Port load_value, input, CHANNELS*WIDTH: per-channel maximum iteration count; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port step, input, CHANNELS: per-channel "one iteration done" strobe.
REQ-008 Port escaped, input, CHANNELS: per-channel "|z| exceeded bound" strobe.
REQ-009 Port busy, output, CHANNELS: channel not IDLE.
REQ-010 Port remaining, output, CHANNELS*WIDTH: per-channel remaining-iteration register.
REQ-011 Port res_valid, output, 1; res_ready, input, 1: result handshake.
REQ-012 Port res_chan, output, clog2(CHANNELS) (minimum 1): channel index of the result.
REQ-013 Port res_count, output, WIDTH: iterations consumed.
REQ-014 Port res_escaped, output, 1: 1 = escaped; 0 = budget exhausted.

Function
REQ-015 Each channel SHALL implement states IDLE, RUN and DONE, and SHALL hold an origin register and a remaining register.
REQ-016 IDLE with load=1: remaining and origin <= load_value; next state RUN, or DONE (count 0, escaped 0) when load_value==0.
REQ-017 Load SHALL be ignored in RUN and DONE; step and escaped SHALL be ignored outside RUN.
REQ-018 RUN with escaped=1: next state DONE, escaped flag 1, count = origin - remaining; escape wins over a simultaneous step, and remaining is not decremented.
REQ-019 RUN with step=1 and escaped=0: remaining <= remaining-1; when remaining==1 before the step, next state DONE, escaped flag 0, count = origin.
REQ-020 Subtraction SHALL be unsigned modulo 2^WIDTH; remaining SHALL never wrap below 0.
REQ-021 Output slot: when res_valid=0, or res_valid&res_ready, the slot SHALL load from the lowest-index DONE channel; that channel returns to IDLE in the same edge.
REQ-022 While res_valid=1 and res_ready=0, res_chan, res_count and res_escaped SHALL be held stable.
REQ-023 Latency: final step at cycle t gives DONE at t+1 and res_valid at t+2 when the slot is free; the channel SHALL accept load at t+2.
REQ-024 Sustained throughput SHALL be one result per cycle while res_ready=1.
REQ-025 A channel waiting in DONE SHALL hold its result indefinitely and SHALL never drop it.

Reset
REQ-026 Reset SHALL force all channels to IDLE, all remaining/origin registers to 0, res_valid/res_chan/res_count/res_escaped to 0, and the stats counter to 0.
REQ-027 Reset SHALL take priority over load, step, escaped and res_ready in the same cycle; work in flight mid-operation is discarded.

Configuration
REQ-028 With MANDELBROT_ITER_STATS_EN defined: add output total_iter, 32 bits, which increments by the count of accepted steps (accepted = step while RUN, escaped=0) each cycle and saturates at 2^32-1.
REQ-029 Without MANDELBROT_ITER_STATS_EN: port total_iter and its logic are absent; all other behaviour is identical.

Structure
REQ-030 The channel state enum (IDLE/RUN/DONE) SHALL live in shared package mandelbrot_pkg, alongside the default WIDTH constant.
REQ-031 One sub-module mandelbrot_iter_chan SHALL implement a single channel and be instantiated CHANNELS times; arbitration and the output slot live in the top level.

Verification
REQ-032 Ch0 load 5, 5 consecutive steps, res_ready=1 -> res_valid 2 cycles after the last step, chan 0, count 5, escaped 0.
REQ-033 Ch1 load 100, 7 steps, escaped pulse together with 8th step -> count 7, escaped 1, remaining[1] reads 93 at DONE.
REQ-034 Ch2 load 0 -> DONE next cycle, result count 0, escaped 0, no steps needed.
REQ-035 Ch0 and ch3 finish same cycle, res_ready=0 for 4 cycles -> ch0 result held stable; ch3 delivered the cycle after the handshake.
REQ-036 Reset asserted while 4 channels in RUN with load=1 -> busy=0, res_valid=0, all remaining 0 next cycle.
REQ-037 STATS_EN build: 4 channels each step 3 times in parallel -> total_iter=12; load during RUN ignored, origin unchanged.
